// File: rtl/leds_frame_serializer.sv
// WS2812 frame serializer: fetches GRB pixels over a req/valid handshake and drives the LED line.
// Optional macro LEDS_UNDERRUN_DETECT_EN enables the sticky underrun flag.
module leds_frame_serializer #(
   parameter int NUM_LEDS  = 110,
   parameter int BIT_CLK   = 63,
   parameter int T0H_CLK   = 20,
   parameter int T1H_CLK   = 40,
   parameter int LATCH_CLK = 3000
) (
   input  logic        clk,
   input  logic        force_reset,
   input  logic        update_frame,
   output logic        busy,
   output logic        pix_req,
   output logic [6:0]  pix_idx,
   input  logic        pix_valid,
   input  logic [23:0] pix_data,
   output logic        leds_line,
   output logic        frame_done,
   output logic        underrun
);

   localparam int SW = (BIT_CLK > 1) ? $clog2(BIT_CLK) : 1;
   localparam int LW = (LATCH_CLK > 1) ? $clog2(LATCH_CLK) : 1;

   localparam logic [SW-1:0] SLOT_LAST  = SW'(BIT_CLK - 1);
   localparam logic [SW:0]   T0H_V      = (SW+1)'(T0H_CLK);
   localparam logic [SW:0]   T1H_V      = (SW+1)'(T1H_CLK);
   localparam logic [LW-1:0] LATCH_LAST = LW'(LATCH_CLK - 1);
   localparam logic [6:0]    LAST_IDX   = 7'(NUM_LEDS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, SEND, LATCH} state_t;

   state_t        state_q, state_d;
   logic [SW-1:0] slot_q, slot_d;
   logic [4:0]    bit_q, bit_d;
   logic [23:0]   shift_q, shift_d;
   logic [23:0]   hold_q, hold_d;
   logic          hold_full_q, hold_full_d;
   logic          req_out_q, req_out_d;
   logic          last_q, last_d;
   logic [6:0]    idx_q, idx_d;
   logic          req_q, req_d;
   logic          line_q, line_d;
   logic          done_q, done_d;
   logic          busy_q, busy_d;
   logic          pending_q, pending_d;
   logic [LW-1:0] latch_q, latch_d;
   logic          take_valid;
   logic          load_en;
   logic [23:0]   load_data;
`ifdef LEDS_UNDERRUN_DETECT_EN
   logic          underrun_q, underrun_d;
`endif

   always_ff @(posedge clk or posedge force_reset) begin
      if (force_reset) begin
         state_q     <= IDLE;
         slot_q      <= '0;
         bit_q       <= '0;
         shift_q     <= '0;
         hold_q      <= '0;
         hold_full_q <= 1'b0;
         req_out_q   <= 1'b0;
         last_q      <= 1'b0;
         idx_q       <= '0;
         req_q       <= 1'b0;
         line_q      <= 1'b0;
         done_q      <= 1'b0;
         busy_q      <= 1'b0;
         pending_q   <= 1'b0;
         latch_q     <= '0;
`ifdef LEDS_UNDERRUN_DETECT_EN
         underrun_q  <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         slot_q      <= slot_d;
         bit_q       <= bit_d;
         shift_q     <= shift_d;
         hold_q      <= hold_d;
         hold_full_q <= hold_full_d;
         req_out_q   <= req_out_d;
         last_q      <= last_d;
         idx_q       <= idx_d;
         req_q       <= req_d;
         line_q      <= line_d;
         done_q      <= done_d;
         busy_q      <= busy_d;
         pending_q   <= pending_d;
         latch_q     <= latch_d;
`ifdef LEDS_UNDERRUN_DETECT_EN
         underrun_q  <= underrun_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      slot_d      = slot_q;
      bit_d       = bit_q;
      shift_d     = shift_q;
      hold_d      = hold_q;
      hold_full_d = hold_full_q;
      req_out_d   = req_out_q;
      last_d      = last_q;
      idx_d       = idx_q;
      req_d       = 1'b0;
      done_d      = 1'b0;
      pending_d   = pending_q;
      latch_d     = latch_q;
      load_en     = 1'b0;
      load_data   = pix_data;
`ifdef LEDS_UNDERRUN_DETECT_EN
      underrun_d  = underrun_q;
`endif
      // A response only counts while a request is outstanding; strays are dropped.
      take_valid  = pix_valid && req_out_q;

      if (update_frame && (state_q != IDLE))
         pending_d = 1'b1;

      case (state_q)
         IDLE: begin
            if (update_frame) begin
               state_d   = FETCH;
               idx_d     = '0;
               req_d     = 1'b1;
               req_out_d = 1'b1;
            end
         end
         FETCH: begin
            if (take_valid) begin
               load_en   = 1'b1;
               load_data = pix_data;
               req_out_d = 1'b0;
            end
         end
         SEND: begin
            if (take_valid) begin
               hold_d      = pix_data;
               hold_full_d = 1'b1;
               req_out_d   = 1'b0;
            end
            if (slot_q == SLOT_LAST) begin
               slot_d = '0;
               if (bit_q != 5'd0) begin
                  bit_d   = bit_q - 5'd1;
                  shift_d = {shift_q[22:0], 1'b0};
               end else if (last_q) begin
                  state_d = LATCH;
                  latch_d = '0;
               end else if (hold_full_q) begin
                  load_en     = 1'b1;
                  load_data   = hold_q;
                  hold_full_d = 1'b0;
               end else if (take_valid) begin
                  // Response landing on the final slot bypasses the holding register.
                  load_en     = 1'b1;
                  load_data   = pix_data;
                  hold_full_d = 1'b0;
               end else begin
                  state_d = FETCH;
`ifdef LEDS_UNDERRUN_DETECT_EN
                  underrun_d = 1'b1;
`endif
               end
            end else begin
               slot_d = slot_q + SW'(1);
            end
         end
         LATCH: begin
            if (latch_q == LATCH_LAST) begin
               done_d = 1'b1;
               if (pending_q || update_frame) begin
                  state_d   = FETCH;
                  idx_d     = '0;
                  req_d     = 1'b1;
                  req_out_d = 1'b1;
                  pending_d = 1'b0;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               latch_d = latch_q + LW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // The pixel being loaded is always the one last requested (idx_q).
      if (load_en) begin
         state_d = SEND;
         shift_d = load_data;
         bit_d   = 5'd23;
         slot_d  = '0;
         last_d  = (idx_q == LAST_IDX);
         if (idx_q != LAST_IDX) begin
            idx_d     = idx_q + 7'd1;
            req_d     = 1'b1;
            req_out_d = 1'b1;
         end
      end

      busy_d = (state_d != IDLE);
      line_d = (state_d == SEND) &&
               ({1'b0, slot_d} < (shift_d[23] ? T1H_V : T0H_V));
   end

   assign busy       = busy_q;
   assign pix_req    = req_q;
   assign pix_idx    = idx_q;
   assign leds_line  = line_q;
   assign frame_done = done_q;
`ifdef LEDS_UNDERRUN_DETECT_EN
   assign underrun   = underrun_q;
`else
   assign underrun   = 1'b0;
`endif

endmodule

// File: tb/tb_leds_frame_serializer.sv
// Directed self-checking bench for leds_frame_serializer (small frame, short timings).
module tb_leds_frame_serializer;

   localparam int NL = 2;
   localparam int BC = 10;
   localparam int T0 = 3;
   localparam int T1 = 6;
   localparam int LC = 20;
`ifdef LEDS_UNDERRUN_DETECT_EN
   localparam logic UR_EXP = 1'b1;
`else
   localparam logic UR_EXP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        force_reset;
   logic        update_frame;
   logic        busy;
   logic        pix_req;
   logic [6:0]  pix_idx;
   logic        pix_valid;
   logic [23:0] pix_data;
   logic        leds_line;
   logic        frame_done;
   logic        underrun;

   logic        resp_valid;
   logic        stray_valid;
   logic [23:0] resp_data;
   logic [23:0] pix_tab [2];
   int unsigned lat1;
   logic        mon_clr = 1'b1;

   int unsigned n_vec = 0;
   int unsigned n_err = 0;

   int unsigned hi_runs[$];
   int unsigned periods[$];
   int unsigned low_runs[$];
   logic [6:0]  req_idx[$];
   int unsigned done_cnt;
   int unsigned rise_cnt;

   assign pix_valid = resp_valid | stray_valid;
   assign pix_data  = stray_valid ? 24'hAAAAAA : resp_data;

   always #5 clk = ~clk;

   leds_frame_serializer #(
      .NUM_LEDS  (NL),
      .BIT_CLK   (BC),
      .T0H_CLK   (T0),
      .T1H_CLK   (T1),
      .LATCH_CLK (LC)
   ) dut (
      .clk          (clk),
      .force_reset  (force_reset),
      .update_frame (update_frame),
      .busy         (busy),
      .pix_req      (pix_req),
      .pix_idx      (pix_idx),
      .pix_valid    (pix_valid),
      .pix_data     (pix_data),
      .leds_line    (leds_line),
      .frame_done   (frame_done),
      .underrun     (underrun)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   // Line monitor: high-run lengths, rise-to-rise periods, low run before frame_done.
   initial begin
      int unsigned hi_cnt, per_cnt, low_cnt;
      logic prev;
      hi_cnt = 0; per_cnt = 0; low_cnt = 0; prev = 1'b0;
      done_cnt = 0; rise_cnt = 0;
      forever begin
         @(negedge clk);
         if (mon_clr) begin
            hi_runs.delete(); periods.delete(); low_runs.delete(); req_idx.delete();
            done_cnt = 0; rise_cnt = 0; hi_cnt = 0; per_cnt = 0; low_cnt = 0;
            prev = leds_line;
         end else begin
            if (frame_done) begin
               done_cnt++;
               low_runs.push_back(low_cnt);
            end
            if (pix_req) req_idx.push_back(pix_idx);
            if (leds_line) begin
               if (!prev) begin
                  rise_cnt++;
                  if (rise_cnt > 1) periods.push_back(per_cnt);
                  per_cnt = 0;
                  hi_cnt  = 0;
               end
               hi_cnt++;
            end else begin
               if (prev) begin
                  hi_runs.push_back(hi_cnt);
                  low_cnt = 0;
               end
               low_cnt++;
            end
            per_cnt++;
            prev = leds_line;
         end
      end
   end

   // Pixel source: answers each request; pixel 1 uses latency lat1.
   initial begin
      logic [6:0] idx;
      resp_valid = 1'b0;
      resp_data  = '0;
      forever begin
         @(negedge clk);
         if (pix_req) begin
            idx = pix_idx;
            repeat ((idx == 7'd1) ? lat1 : 1) @(posedge clk);
            #1;
            resp_valid = 1'b1;
            resp_data  = pix_tab[idx[0]];
            @(posedge clk);
            #1;
            resp_valid = 1'b0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int unsigned n);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic pulse_update();
      @(posedge clk); #1 update_frame = 1'b1;
      @(posedge clk); #1 update_frame = 1'b0;
   endtask

   task automatic clear_mon();
      @(posedge clk); #1 mon_clr = 1'b1;
      @(posedge clk); #1 mon_clr = 1'b0;
   endtask

   task automatic wait_done(input int unsigned target, input int unsigned budget);
      int unsigned k;
      k = 0;
      while (done_cnt < target && k < budget) begin
         tick(1);
         k++;
      end
      if (done_cnt < target) check("done_timeout", done_cnt, target);
   endtask

   task automatic wait_runs(input int unsigned target, input int unsigned budget);
      int unsigned k;
      k = 0;
      while (hi_runs.size() < target && k < budget) begin
         tick(1);
         k++;
      end
      if (hi_runs.size() < target) check("runs_timeout", hi_runs.size(), target);
   endtask

   // Both pixels, MSB first: expected high time per bit slot.
   task automatic check_runs();
      int unsigned p, b, e;
      check("run_count", hi_runs.size(), 48);
      for (int k = 0; k < 48 && k < hi_runs.size(); k++) begin
         p = k / 24;
         b = 23 - (k % 24);
         e = pix_tab[p][b] ? T1 : T0;
         check($sformatf("hi_run[%0d]", k), hi_runs[k], e);
      end
   endtask

   task automatic check_periods(input int unsigned exp_odd_cnt, input int unsigned exp_odd);
      int unsigned odd_cnt, odd;
      odd_cnt = 0; odd = 0;
      foreach (periods[i]) begin
         if (periods[i] != BC) begin
            odd_cnt++;
            odd = periods[i];
         end
      end
      check("period_count", periods.size(), 47);
      check("odd_periods", odd_cnt, exp_odd_cnt);
      if (exp_odd_cnt != 0) check("gap_period", odd, exp_odd);
   endtask

   initial begin
      pix_tab[0]   = 24'hFF0000;
      pix_tab[1]   = 24'h000001;
      lat1         = 1;
      force_reset  = 1'b1;
      update_frame = 1'b0;
      stray_valid  = 1'b0;

      // Reset state
      tick(3);
      check("rst_line", leds_line, 0);
      check("rst_busy", busy, 0);
      check("rst_req", pix_req, 0);
      check("rst_idx", pix_idx, 0);
      check("rst_done", frame_done, 0);
      check("rst_underrun", underrun, 0);
      @(posedge clk); #1 force_reset = 1'b0;
      clear_mon();
      tick(10);
      check("idle_busy", busy, 0);
      check("idle_no_req", req_idx.size(), 0);

      // Normal frame, 1-cycle latency
      clear_mon();
      pulse_update();
      wait_done(1, 1000);
      check("fd_busy", busy, 0);
      check_runs();
      check_periods(0, 0);
      check("latch_low", low_runs.size() > 0 ? low_runs[0] : 0, BC - T1 + LC);
      check("req_count", req_idx.size(), 2);
      check("req0", req_idx.size() > 0 ? req_idx[0] : 7'h7f, 0);
      check("req1", req_idx.size() > 1 ? req_idx[1] : 7'h7f, 1);
      check("no_underrun", underrun, 0);
      tick(30);
      check("single_done", done_cnt, 1);
      check("end_busy", busy, 0);

      // Stray pix_valid during LATCH
      clear_mon();
      pulse_update();
      wait_runs(48, 1000);
      tick(8);
      @(posedge clk); #1 stray_valid = 1'b1;
      tick(1);
      check("stray_latch_line", leds_line, 0);
      check("stray_latch_busy", busy, 1);
      @(posedge clk); #1 stray_valid = 1'b0;
      wait_done(1, 200);
      check("stray_latch_low", low_runs.size() > 0 ? low_runs[0] : 0, BC - T1 + LC);
      check("stray_latch_reqs", req_idx.size(), 2);
      tick(30);
      check("stray_latch_done", done_cnt, 1);

      // Stray pix_valid in IDLE
      clear_mon();
      @(posedge clk); #1 stray_valid = 1'b1;
      @(posedge clk); #1 stray_valid = 1'b0;
      tick(30);
      check("stray_idle_busy", busy, 0);
      check("stray_idle_rise", rise_cnt, 0);
      check("stray_idle_req", req_idx.size(), 0);
      check("stray_idle_done", done_cnt, 0);

      // update_frame during SEND and during LATCH -> one extra frame
      clear_mon();
      pulse_update();
      tick(50);
      pulse_update();
      wait_runs(48, 1000);
      tick(8);
      pulse_update();
      wait_done(1, 200);
      check("pend_req", pix_req, 1);
      check("pend_idx", pix_idx, 0);
      check("pend_busy", busy, 1);
      wait_done(2, 1500);
      tick(600);
      check("pend_done", done_cnt, 2);
      check("pend_idle", busy, 0);
      check("pend_runs", hi_runs.size(), 96);
      check("pend_reqs", req_idx.size(), 4);
      for (int i = 0; i < 4 && i < req_idx.size(); i++)
         check($sformatf("pend_req_idx[%0d]", i), req_idx[i], i % 2);

      // Late pixel 1 -> underrun fallback through FETCH
      clear_mon();
      lat1 = 300;
      pulse_update();
      wait_done(1, 2000);
      check_runs();
      check_periods(1, 300 - 229);
      check("ur_flag", underrun, UR_EXP);
      check("ur_latch_low", low_runs.size() > 0 ? low_runs[0] : 0, BC - T1 + LC);
      check("ur_reqs", req_idx.size(), 2);
      tick(30);
      check("ur_done", done_cnt, 1);
      check("ur_sticky", underrun, UR_EXP);
      lat1 = 1;

      // Reset mid-bit while line is high
      clear_mon();
      pulse_update();
      begin
         int unsigned k;
         k = 0;
         while (!leds_line && k < 50) begin
            tick(1);
            k++;
         end
      end
      tick(2);
      check("pre_rst_line", leds_line, 1);
      force_reset = 1'b1;
      #1;
      check("mid_rst_line", leds_line, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_req", pix_req, 0);
      check("mid_rst_idx", pix_idx, 0);
      check("mid_rst_underrun", underrun, 0);
      @(posedge clk); #1 force_reset = 1'b0;
      clear_mon();
      tick(100);
      check("post_rst_req", req_idx.size(), 0);
      check("post_rst_rise", rise_cnt, 0);
      check("post_rst_busy", busy, 0);
      check("post_rst_done", done_cnt, 0);

      // Fresh frame after reset
      clear_mon();
      pulse_update();
      wait_done(1, 1000);
      check_runs();
      check("fresh_reqs", req_idx.size(), 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/leds_frame_serializer.md
LEDS_FRAME_SERIALIZER -- requirements
Module: leds_frame_serializer

Interface
REQ-001 SHALL have parameter NUM_LEDS, default 110, pixels per frame (positions 0..MAX_POS).
REQ-002 SHALL have parameter BIT_CLK, default 63, clocks per WS2812 bit slot.
REQ-003 SHALL have parameter T0H_CLK, default 20, high clocks for a 0 bit; T1H_CLK, default 40, high clocks for a 1 bit.
REQ-004 SHALL have parameter LATCH_CLK, default 3000, low clocks of end-of-frame latch.
REQ-005 SHALL have ports: clk  in  1  sole clock; force_reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: update_frame  in  1  one-cycle frame start request; busy  out  1  frame in progress.
REQ-007 SHALL have ports: pix_req  out  1  one-cycle pixel fetch request; pix_idx  out  7  pixel index requested.
REQ-008 SHALL have ports: pix_valid  in  1  one-cycle response strobe; pix_data  in  24  GRB colour, G[23:16] R[15:8] B[7:0].
REQ-009 SHALL have ports: leds_line  out  1  WS2812 data line; frame_done  out  1  one-cycle end-of-frame pulse; underrun  out  1  sticky data-late flag.

Function
REQ-010 SHALL implement states IDLE, FETCH, SEND, LATCH.
REQ-011 IDLE: leds_line=0, busy=0; update_frame -> FETCH with pix_idx=0 and pix_req pulsed in the same transition cycle.
REQ-012 FETCH: leds_line=0; waits for pix_valid (latency >=1 cycle after pix_req, unbounded); on pix_valid loads shift register, bit counter=23, slot counter=0 -> SEND.
REQ-013 SEND: per bit, slot counter runs 0..BIT_CLK-1; leds_line=1 while slot < (bit ? T1H_CLK : T0H_CLK), else 0; bits MSB first (bit 23 first).
REQ-014 SEND: if pixel is not last, pix_req SHALL pulse with pix_idx+1 in the cycle slot 0 of bit 23 begins (prefetch); pix_valid data SHALL land in a one-entry holding register.
REQ-015 At end of bit 0 of a non-last pixel: holding register full -> next pixel starts at slot 0 on the next cycle with no gap; empty -> FETCH, underrun set, pix_req not re-pulsed.
REQ-016 pix_valid when no request is outstanding SHALL be ignored.
REQ-017 At end of bit 0 of pixel NUM_LEDS-1 -> LATCH; leds_line=0 for exactly LATCH_CLK cycles; then frame_done pulses 1 cycle; busy=0 in that same cycle.
REQ-018 busy SHALL be 1 in FETCH, SEND, LATCH.
REQ-019 update_frame while busy SHALL set a one-deep pending flag (further requests merged); at LATCH exit with pending set -> FETCH with pix_idx=0 (pending cleared, frame_done still pulses), else -> IDLE.
REQ-020 Counters SHALL be sized by clog2 of their parameter; pix_idx SHALL never exceed NUM_LEDS-1.
REQ-021 leds_line SHALL be driven from a flop (glitch-free).

Reset
REQ-022 force_reset high SHALL immediately force: state IDLE, leds_line=0, busy=0, pix_req=0, pix_idx=0, frame_done=0, underrun=0, pending=0, holding register empty, all counters 0.
REQ-023 Reset mid-frame SHALL abandon the frame; after release, first frame starts only on a new update_frame.

Configuration
REQ-024 Macro LEDS_UNDERRUN_DETECT_EN defined: underrun set per REQ-015, cleared only by reset.
REQ-025 Macro LEDS_UNDERRUN_DETECT_EN undefined: underrun tied 0; FETCH fallback of REQ-015 still occurs.

Verification
REQ-026 NUM_LEDS=2, BIT_CLK=10, T0H=3, T1H=6, LATCH=20; update_frame, pix 0=24'hFF0000, pix 1=24'h000001 with 1-cycle latency -> 8 slots high 6, 16 slots high 3; then 23 slots high 3, 1 slot high 6; 20 low; frame_done once.
REQ-027 Same setup, pixel 1 response delayed 300 cycles -> line low after pixel 0, underrun=1 (macro on) / 0 (macro off), frame completes normally.
REQ-028 update_frame during SEND and again during LATCH -> exactly one extra frame, pix_idx restarts at 0 immediately after frame_done.
REQ-029 force_reset asserted mid-bit with leds_line=1 -> leds_line=0 same cycle; no pix_req until new update_frame.
REQ-030 Stray pix_valid in IDLE and during LATCH -> no state change, no output change.
